ctr_keystream_combiner: RTL and testbench

Downstream stage of the AES-256 CTR encryption path. It buffers plaintext blocks, pairs each one with the next encrypted-counter (keystream) block from the AES core, and XORs them to produce ciphertext blocks. It handles a partial final block by zeroing the unused bytes. All three streams use valid/ready handshakes, so the AES core and plaintext source can run at independent rates.

---
 rtl/ctr_keystream_combiner.sv | 127 ++++++++++++
 tb/tb_ctr_keystream_combiner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctr_keystream_combiner.sv
// CTR-mode combiner: buffers plaintext blocks, pairs each with the next keystream
// block, and emits masked ciphertext with valid/ready handshakes on all three streams.
module ctr_keystream_combiner #(
    parameter int BLK_W      = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pt_valid,
    output logic             pt_ready,
    input  logic [BLK_W-1:0] pt_data,
    input  logic             pt_last,
    input  logic [4:0]       pt_bytes,
    input  logic             ks_valid,
    output logic             ks_ready,
    input  logic [BLK_W-1:0] ks_data,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic [BLK_W-1:0] ct_data,
    output logic             ct_last,
    output logic [4:0]       ct_bytes,
    output logic [15:0]      blk_count,
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    logic [BLK_W-1:0] fifo_data  [FIFO_DEPTH];
    logic             fifo_last  [FIFO_DEPTH];
    logic [4:0]       fifo_bytes [FIFO_DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic [BLK_W-1:0] ks_reg;
    logic             ks_held;
    state_t           state;

    logic full;
    logic nonempty;
    logic push;
    logic do_join;
    logic ks_accept;
    logic ct_hs;

    // Keeps the leading n bytes (byte 0 is the MSB end) and zeroes the tail.
    function automatic logic [BLK_W-1:0] byte_mask(input logic [4:0] n);
        logic [BLK_W-1:0] m;
        m = '0;
        for (int i = 0; i < BLK_W / 8; i++) begin
            if (i < int'(n)) m[BLK_W-1-8*i -: 8] = 8'hFF;
        end
        return m;
    endfunction

    // Out-of-range counts on a final block fall back to a full block.
    function automatic logic [4:0] norm_bytes(input logic last, input logic [4:0] n);
        if (!last || n == 5'd0 || n > 5'd16) return 5'd16;
        return n;
    endfunction

    assign full      = (count == (AW + 1)'(FIFO_DEPTH));
    assign nonempty  = (count != '0);
    assign pt_ready  = !rst && !full;
    assign push      = pt_valid && pt_ready;
    // FLUSH blocks the next message until its final block has left.
    assign do_join   = nonempty && ks_held && (!ct_valid || ct_ready) && (state != FLUSH);
    assign ks_ready  = !rst && (!ks_held || do_join);
    assign ks_accept = ks_valid && ks_ready;
    assign ct_hs     = ct_valid && ct_ready;
    assign busy      = nonempty || ks_held || ct_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wptr]  <= pt_data;
            fifo_last[wptr]  <= pt_last;
            fifo_bytes[wptr] <= norm_bytes(pt_last, pt_bytes);
        end
        if (ks_accept) ks_reg <= ks_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            ks_held   <= 1'b0;
            ct_valid  <= 1'b0;
            ct_data   <= '0;
            ct_last   <= 1'b0;
            ct_bytes  <= '0;
            blk_count <= '0;
            state     <= IDLE;
        end else begin
            if (push)    wptr <= wptr + AW'(1);
            if (do_join) rptr <= rptr + AW'(1);
            case ({push, do_join})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase

            if (ks_accept)    ks_held <= 1'b1;
            else if (do_join) ks_held <= 1'b0;

            if (do_join) begin
                ct_valid <= 1'b1;
                ct_data  <= (fifo_data[rptr] ^ ks_reg) & byte_mask(fifo_bytes[rptr]);
                ct_last  <= fifo_last[rptr];
                ct_bytes <= fifo_bytes[rptr];
            end else if (ct_hs) begin
                ct_valid <= 1'b0;
            end

            if (ct_hs) blk_count <= ct_last ? 16'd0 : blk_count + 16'd1;

            case (state)
                IDLE:    if (do_join) state <= fifo_last[rptr] ? FLUSH : ACTIVE;
                ACTIVE:  if (do_join && fifo_last[rptr]) state <= FLUSH;
                FLUSH:   if (ct_hs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_keystream_combiner.sv
// Directed bench for ctr_keystream_combiner: vector table plus multi-cycle sequences.
module tb_ctr_keystream_combiner;

    logic         clk = 1'b0;
    logic         rst;
    logic         pt_valid;
    logic         pt_ready;
    logic [127:0] pt_data;
    logic         pt_last;
    logic [4:0]   pt_bytes;
    logic         ks_valid;
    logic         ks_ready;
    logic [127:0] ks_data;
    logic         ct_valid;
    logic         ct_ready;
    logic [127:0] ct_data;
    logic         ct_last;
    logic [4:0]   ct_bytes;
    logic [15:0]  blk_count;
    logic         busy;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [127:0] pt;
        logic         last;
        logic [4:0]   nb;
        logic [127:0] ks;
        logic [127:0] ct;
        logic         elast;
        logic [4:0]   ebytes;
        logic [15:0]  eblk;
    } vec_t;

    vec_t vecs[10];

    ctr_keystream_combiner #(.BLK_W(128), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .pt_last(pt_last), .pt_bytes(pt_bytes),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
        .ct_last(ct_last), .ct_bytes(ct_bytes),
        .blk_count(blk_count), .busy(busy)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pblk(input int i);
        logic [7:0] b;
        b = 8'h10 + 8'(i);
        return {16{b}};
    endfunction

    function automatic logic [127:0] kblk(input int i);
        logic [7:0] b;
        b = 8'hC0 + 8'(i);
        return {16{b}};
    endfunction

    task automatic idle_inputs();
        pt_valid = 1'b0; pt_data = '0; pt_last = 1'b0; pt_bytes = '0;
        ks_valid = 1'b0; ks_data = '0; ct_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        ct_ready = 1'b1;
        pt_valid = 1'b1; pt_data = v.pt; pt_last = v.last; pt_bytes = v.nb;
        ks_valid = 1'b1; ks_data = v.ks;
        tick();
        pt_valid = 1'b0; ks_valid = 1'b0;
        check($sformatf("vec%0d_latency_ct_valid", idx), ct_valid, 0);
        tick();
        check($sformatf("vec%0d_ct_valid", idx), ct_valid, 1);
        check($sformatf("vec%0d_ct_data", idx), ct_data, v.ct);
        check($sformatf("vec%0d_ct_last", idx), ct_last, v.elast);
        check($sformatf("vec%0d_ct_bytes", idx), ct_bytes, v.ebytes);
        tick();
        check($sformatf("vec%0d_ct_valid_drop", idx), ct_valid, 0);
        check($sformatf("vec%0d_blk_count", idx), blk_count, v.eblk);
    endtask

    initial begin
        vecs[0] = '{pt: '0, last: 1'b0, nb: 5'd0, ks: 128'h000102030405060708090A0B0C0D0E0F,
                    ct: 128'h000102030405060708090A0B0C0D0E0F, elast: 1'b0, ebytes: 5'd16, eblk: 16'd1};
        vecs[1] = '{pt: {16{8'hFF}}, last: 1'b1, nb: 5'd5, ks: '0,
                    ct: {{5{8'hFF}}, {11{8'h00}}}, elast: 1'b1, ebytes: 5'd5, eblk: 16'd0};
        vecs[2] = '{pt: 128'h0123456789ABCDEF0123456789ABCDEF, last: 1'b0, nb: 5'd16, ks: {16{8'hFF}},
                    ct: 128'hFEDCBA9876543210FEDCBA9876543210, elast: 1'b0, ebytes: 5'd16, eblk: 16'd1};
        vecs[3] = '{pt: {16{8'hA5}}, last: 1'b0, nb: 5'd7, ks: {16{8'h5A}},
                    ct: {16{8'hFF}}, elast: 1'b0, ebytes: 5'd16, eblk: 16'd2};
        vecs[4] = '{pt: {16{8'h11}}, last: 1'b1, nb: 5'd16, ks: {16{8'h22}},
                    ct: {16{8'h33}}, elast: 1'b1, ebytes: 5'd16, eblk: 16'd0};
        vecs[5] = '{pt: {16{8'hF0}}, last: 1'b1, nb: 5'd0, ks: {16{8'h0F}},
                    ct: {16{8'hFF}}, elast: 1'b1, ebytes: 5'd16, eblk: 16'd0};
        vecs[6] = '{pt: '0, last: 1'b1, nb: 5'd20, ks: {4{32'hDEADBEEF}},
                    ct: {4{32'hDEADBEEF}}, elast: 1'b1, ebytes: 5'd16, eblk: 16'd0};
        vecs[7] = '{pt: {16{8'h77}}, last: 1'b1, nb: 5'd1, ks: '0,
                    ct: {8'h77, {15{8'h00}}}, elast: 1'b1, ebytes: 5'd1, eblk: 16'd0};
        vecs[8] = '{pt: '0, last: 1'b0, nb: 5'd3, ks: {16{8'hFF}},
                    ct: {16{8'hFF}}, elast: 1'b0, ebytes: 5'd16, eblk: 16'd1};
        vecs[9] = '{pt: '0, last: 1'b1, nb: 5'd15, ks: {16{8'hFF}},
                    ct: {{15{8'hFF}}, 8'h00}, elast: 1'b1, ebytes: 5'd15, eblk: 16'd0};

        // Reset state, including ready gating while rst is high.
        idle_inputs();
        rst = 1'b1;
        pt_valid = 1'b1; ks_valid = 1'b1;
        tick();
        tick();
        check("rst_pt_ready", pt_ready, 0);
        check("rst_ks_ready", ks_ready, 0);
        pt_valid = 1'b0; ks_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_ct_valid", ct_valid, 0);
        check("rst_ct_data", ct_data, 0);
        check("rst_ct_last", ct_last, 0);
        check("rst_ct_bytes", ct_bytes, 0);
        check("rst_blk_count", blk_count, 0);
        check("rst_busy", busy, 0);
        check("rst_pt_ready_after", pt_ready, 1);
        check("rst_ks_ready_after", ks_ready, 1);

        for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

        // FIFO full, then four keystream blocks back-to-back.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pt_valid = 1'b1; pt_data = pblk(i);
            #1;
            if (i == 4) check("full_pt_ready", pt_ready, 0);
            tick();
        end
        pt_valid = 1'b0;
        ks_valid = 1'b1; ks_data = kblk(0);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) ks_data = kblk(i + 1);
            else ks_valid = 1'b0;
            tick();
            check($sformatf("full_ct%0d_valid", i), ct_valid, 1);
            check($sformatf("full_ct%0d_data", i), ct_data, pblk(i) ^ kblk(i));
        end
        tick();
        check("full_ct_valid_end", ct_valid, 0);
        check("full_pt_ready_end", pt_ready, 1);
        check("full_blk_count", blk_count, 4);

        // Backpressure: output must hold while ct_ready is low.
        do_reset();
        ct_ready = 1'b0;
        pt_valid = 1'b1; pt_data = pblk(0); ks_valid = 1'b1; ks_data = kblk(0);
        tick();
        pt_data = pblk(1); ks_data = kblk(1);
        tick();
        pt_data = pblk(2); ks_data = kblk(2);
        tick();
        pt_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("bp_hold%0d_data", i), ct_data, pblk(0) ^ kblk(0));
            check($sformatf("bp_hold%0d_ks_ready", i), ks_ready, 0);
            tick();
        end
        check("bp_hold_valid", ct_valid, 1);
        ct_ready = 1'b1;
        tick();
        ks_valid = 1'b0;
        check("bp_rel1_data", ct_data, pblk(1) ^ kblk(1));
        tick();
        check("bp_rel2_data", ct_data, pblk(2) ^ kblk(2));
        check("bp_rel2_valid", ct_valid, 1);
        tick();
        check("bp_end_valid", ct_valid, 0);
        check("bp_blk_count", blk_count, 3);

        // Keystream arrives first and waits for plaintext.
        do_reset();
        ks_valid = 1'b1; ks_data = kblk(5);
        tick();
        ks_valid = 1'b0;
        #1;
        check("ksf_ks_ready", ks_ready, 0);
        check("ksf_busy", busy, 1);
        tick();
        tick();
        check("ksf_ct_valid_wait", ct_valid, 0);
        pt_valid = 1'b1; pt_data = pblk(5);
        tick();
        pt_valid = 1'b0;
        check("ksf_ct_valid_1cyc", ct_valid, 0);
        tick();
        check("ksf_ct_valid_2cyc", ct_valid, 1);
        check("ksf_ct_data", ct_data, pblk(5) ^ kblk(5));

        // Reset in the middle of a four-block message.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pt_valid = 1'b1; pt_data = pblk(i);
            tick();
        end
        pt_valid = 1'b0;
        ks_valid = 1'b1; ks_data = kblk(0);
        tick();
        ks_data = kblk(1);
        tick();
        ks_data = kblk(2);
        tick();
        check("mid_ct1_data", ct_data, pblk(1) ^ kblk(1));
        check("mid_blk_before", blk_count, 1);
        ks_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_pt_ready", pt_ready, 0);
        tick();
        rst = 1'b0;
        check("mid_ct_valid", ct_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_blk_count", blk_count, 0);
        tick();
        check("mid_no_leftover", ct_valid, 0);
        apply_vec(vecs[8], 100);
        apply_vec(vecs[9], 101);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
